// File: rtl/demux_reg_bank_1x16.sv
// Write side of a 16-entry operand bank: a handshaked demux writes one register per
// accepted request, and a clear sweep resets the bank one register per cycle.

module demux_reg_bank_1x16_lane #(
  parameter int            N       = 16,
  parameter logic [N-1:0]  CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_we,
  input  logic         i_ce,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);
  logic [N-1:0] r_q;

  // Write and clear enables never overlap: writes are only taken while IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_q <= '0;
    else if (i_ce) r_q <= CLR_VAL;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module demux_reg_bank_1x16 #(
  parameter int            n       = 16,
  parameter logic [n-1:0]  CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] d,
  input  logic [3:0]   s,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic         clr_req,
  output logic         busy,
  output logic [n-1:0] q0,
  output logic [n-1:0] q1,
  output logic [n-1:0] q2,
  output logic [n-1:0] q3,
  output logic [n-1:0] q4,
  output logic [n-1:0] q5,
  output logic [n-1:0] q6,
  output logic [n-1:0] q7,
  output logic [n-1:0] q8,
  output logic [n-1:0] q9,
  output logic [n-1:0] q10,
  output logic [n-1:0] q11,
  output logic [n-1:0] q12,
  output logic [n-1:0] q13,
  output logic [n-1:0] q14,
  output logic [n-1:0] q15,
  output logic [15:0]  last_wr
);
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              r_state;
  logic [3:0]          r_idx;
  logic [15:0]         r_last_wr;
  logic [15:0]         w_we;
  logic [15:0]         w_ce;
  logic [15:0][n-1:0]  w_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= 4'd0;
      r_last_wr <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (wr_valid) r_last_wr <= 16'b1 << s;
          if (clr_req) begin
            r_state <= CLEAR;
            r_idx   <= 4'd0;
          end
        end
        CLEAR: begin
          // idx wraps 15->0 on the final sweep cycle, leaving it ready for the next sweep.
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd15) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_ready = (r_state == IDLE);
  assign busy     = (r_state == CLEAR);
  assign last_wr  = r_last_wr;

  assign w_we = (wr_ready && wr_valid) ? (16'b1 << s)     : 16'd0;
  assign w_ce = busy                   ? (16'b1 << r_idx) : 16'd0;

  for (genvar g = 0; g < 16; g++) begin : g_lane
    demux_reg_bank_1x16_lane #(.N(n), .CLR_VAL(CLR_VAL)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .i_we (w_we[g]),
      .i_ce (w_ce[g]),
      .i_d  (d),
      .o_q  (w_q[g])
    );
  end

  assign q0  = w_q[0];
  assign q1  = w_q[1];
  assign q2  = w_q[2];
  assign q3  = w_q[3];
  assign q4  = w_q[4];
  assign q5  = w_q[5];
  assign q6  = w_q[6];
  assign q7  = w_q[7];
  assign q8  = w_q[8];
  assign q9  = w_q[9];
  assign q10 = w_q[10];
  assign q11 = w_q[11];
  assign q12 = w_q[12];
  assign q13 = w_q[13];
  assign q14 = w_q[14];
  assign q15 = w_q[15];
endmodule

// File: tb/tb_demux_reg_bank_1x16.sv
// Randomized and directed bench for demux_reg_bank_1x16 against a behavioural bank model
// that tracks register contents and the number of sweep cycles still to run.

module tb_demux_reg_bank_1x16;
  localparam logic [15:0] CLR = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d = '0;
  logic [3:0]  s = '0;
  logic        wr_valid = 1'b0;
  logic        clr_req = 1'b0;
  logic        wr_ready, busy;
  logic [15:0] last_wr;
  logic [15:0] dq [16];

  int errs = 0;
  int checks = 0;

  // Behavioural model: bank contents, last write marker, sweep cycles left.
  logic [15:0] m_q [16];
  logic [15:0] m_last;
  int          m_left;

  always #5 clk = ~clk;

  demux_reg_bank_1x16 #(.n(16), .CLR_VAL(CLR)) dut (
    .clk(clk), .rst(rst), .d(d), .s(s), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .clr_req(clr_req), .busy(busy),
    .q0(dq[0]),   .q1(dq[1]),   .q2(dq[2]),   .q3(dq[3]),
    .q4(dq[4]),   .q5(dq[5]),   .q6(dq[6]),   .q7(dq[7]),
    .q8(dq[8]),   .q9(dq[9]),   .q10(dq[10]), .q11(dq[11]),
    .q12(dq[12]), .q13(dq[13]), .q14(dq[14]), .q15(dq[15]),
    .last_wr(last_wr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_q[i] <= '0;
      m_last <= '0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_q[16 - m_left] <= CLR;
      m_left <= m_left - 1;
    end else begin
      if (wr_valid) begin
        m_q[s] <= d;
        m_last <= 16'h1 << s;
      end
      if (clr_req) m_left <= 16;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", {31'd0, busy}, {31'd0, m_left > 0});
      check("wr_ready", {31'd0, wr_ready}, {31'd0, m_left == 0});
      check("last_wr", {16'd0, last_wr}, {16'd0, m_last});
      for (int i = 0; i < 16; i++) check($sformatf("q%0d", i), {16'd0, dq[i]}, {16'd0, m_q[i]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input logic [15:0] v);
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s = 4'(i);
      d = v;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic reset_zero_checks(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s_q%0d", tag, i), {16'd0, dq[i]}, 32'd0);
    check({tag, "_last_wr"}, {16'd0, last_wr}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic start_clear();
    wr_valid = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    bit ok;
    #1;
    reset_zero_checks("por");
    tick();
    tick();
    rst = 1'b0;

    // Async reset with data present, no clock edge.
    fill(16'h5A5A);
    rst = 1'b1;
    #1;
    reset_zero_checks("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Walking writes.
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s = 4'(i);
      d = 16'hA5A0 + 16'(i);
      @(posedge clk);
      #1;
      check($sformatf("walk_q%0d", i), {16'd0, dq[i]}, {16'd0, 16'hA5A0 + 16'(i)});
      check($sformatf("walk_last%0d", i), {16'd0, last_wr}, {16'd0, 16'h1 << i});
      #1;
    end
    wr_valid = 1'b0;

    // Full sweep: busy exactly 16 cycles.
    fill(16'hFFFF);
    start_clear();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check("sweep_len", cnt, 32'd16);
    check("sweep_q15", {16'd0, dq[15]}, {16'd0, CLR});

    // Write held during a sweep is accepted once ready.
    start_clear();
    wr_valid = 1'b1;
    s = 4'd7;
    d = 16'h1234;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("held_wr_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check("held_q7", {16'd0, dq[7]}, 32'h1234);
    #1;
    wr_valid = 1'b0;

    // Write and clear in the same cycle.
    wr_valid = 1'b1;
    s = 4'd3;
    d = 16'hBEEF;
    clr_req = 1'b1;
    tick();
    wr_valid = 1'b0;
    clr_req = 1'b0;
    check("both_q3", {16'd0, dq[3]}, 32'hBEEF);
    check("both_last", {16'd0, last_wr}, 32'h0008);
    check("both_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    wait_idle("both");
    check("both_q3_clr", {16'd0, dq[3]}, {16'd0, CLR});

    // Reset mid-sweep at idx 8, then immediate write.
    fill(16'hC3C3);
    start_clear();
    for (int k = 0; k < 8; k++) tick();
    rst = 1'b1;
    #1;
    reset_zero_checks("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b1;
    s = 4'd15;
    d = 16'h0F0F;
    @(posedge clk);
    #1;
    check("post_rst_q15", {16'd0, dq[15]}, 32'h0F0F);
    check("post_rst_last", {16'd0, last_wr}, 32'h8000);
    #1;
    wr_valid = 1'b0;

    // Random traffic checked every cycle by the model.
    for (int k = 0; k < 600; k++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      s = 4'($urandom_range(0, 15));
      d = 16'($urandom);
      clr_req = ($urandom_range(0, 24) == 0);
      tick();
    end
    wr_valid = 1'b0;
    clr_req = 1'b0;
    tick();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
